i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) for the same bus that the bridge's I2C master drives.
- Provides a local byte register bank that an external I2C master can write to and read from.
- Serves as the on-chip counterpart for loopback verification of the AXI-to-I2C bridge, and as a reusable peripheral.
- Oversamples SCL/SDA on ACLK; no clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target acknowledges.
- NUM_REGS, 16, register bank depth in bytes; power of two, 2..256; PTR_W = log2(NUM_REGS).
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs; minimum 2.

Ports:
- ACLK  input  1  system clock; fACLK >= 10 x fSCL.
- ARESETn  input  1  asynchronous active-low reset.
- SCL  input  1  I2C clock from the master; never driven by this block.
- SDA  inout  1  I2C data; open-drain: driven 1'b0 or 'z, never 1'b1.
- LOCAL_RADDR  input  PTR_W  local read address into the bank.
- LOCAL_RDATA  output  8  bank[LOCAL_RADDR], combinational.
- WR_STROBE  output  1  one-cycle pulse per byte written to the bank by I2C.
- WR_ADDR  output  PTR_W  bank index of that write; valid with WR_STROBE.
- WR_DATA  output  8  byte written; valid with WR_STROBE.
- RD_STROBE  output  1  one-cycle pulse per byte loaded for an I2C read.
- BUSY  output  1  high from address match until STOP or next START.

Behaviour:
- Reset:
  - Bank cleared to 0; pointer 0; state IDLE.
  - SDA released ('z) asynchronously; WR_STROBE, RD_STROBE and BUSY all 0; WR_ADDR/WR_DATA 0.
- Input conditioning and edge detection:
  - SCL/SDA pass through SYNC_STAGES flops, then one history flop each.
  - rise/fall = registered edge detect on the synchronized signals.
- Bus conditions:
  - START = synced SDA fall while synced SCL high.
  - STOP = synced SDA rise while synced SCL high.
  - Both are valid in every state and take priority over bit activity.
- Bit timing:
  - Input bits are sampled on SCL rise, MSB first.
  - SDA output changes only on the ACLK cycle after SCL fall is detected.
- State machine transitions:
  - IDLE: START -> ADDR.
  - ADDR: shift 8 bits (7 address + R/W).
    - On address match: ADDR_ACK, BUSY=1.
    - Otherwise: WAIT_STOP, SDA never driven.
  - ADDR_ACK:
    - Drive SDA low from the next SCL fall.
    - Release SDA on the following SCL fall.
    - Then R/W=0 -> WR_BYTE with first_byte=1; R/W=1 -> RD_BYTE.
  - WR_BYTE: shift 8 bits, then WR_ACK.
    - If first_byte: pointer <= byte[PTR_W-1:0]; upper bits ignored; no WR_STROBE.
    - Else: bank[pointer] <= byte; WR_STROBE=1 with WR_ADDR=pointer, WR_DATA=byte, in the cycle after the 8th SCL rise; pointer <= pointer+1, wrapping mod NUM_REGS.
  - WR_ACK: always ACK (drive low for one SCL period), then return to WR_BYTE.
  - RD_BYTE:
    - On entry (the SCL fall ending the ACK): load shifter <= bank[pointer], pulse RD_STROBE, pointer <= pointer+1 (wrapping).
    - Drive each bit on SCL fall: 0 -> drive low, 1 -> 'z.
    - After the 8th bit, release SDA on SCL fall and go to RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - 0 (ACK) -> RD_BYTE.
    - 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: ignore bits; SDA released; wait for START or STOP.
- Global events:
  - STOP, any state: SDA released same cycle; state IDLE; BUSY=0; pointer retained.
  - Repeated START, any state: SDA released; state ADDR; BUSY=0 until re-match; pointer retained. This supports write-pointer-then-read sequences.
- Conflicts and ordering:
  - Local read and I2C write to the same index in the same cycle: LOCAL_RDATA shows the old value, then the new value the next cycle.
  - WR_STROBE and RD_STROBE are never high together.
  - A mid-byte STOP/START discards the partial byte; no strobe.
- Reset asserted mid-transfer: SDA released immediately (async), all state returns to reset values.

Test Plan:
- Write 0x50+W, ptr 0x03, data 0xA5, 0x5A, STOP -> three ACKs plus address ACK; WR_STROBE twice (WR_ADDR 3/0xA5, then 4/0x5A); LOCAL_RADDR=4 gives 0x5A; BUSY=0 after STOP.
- Write ptr 0x02; repeated START; 0x50+R; read 3 bytes, ACK, ACK, NACK; STOP -> SDA returns bank[2], [3], [4]; three RD_STROBE pulses; SDA released after NACK.
- Address 0x51+W with data -> SDA never low; no strobes; BUSY stays 0; bank unchanged.
- NUM_REGS=16: ptr 0x0F, write 0x11, 0x22 -> bank[15]=0x11, bank[0]=0x22 (wrap); ptr byte 0xF3 selects index 3.
- STOP after 4 bits of a data byte -> no WR_STROBE; state IDLE; next transfer works normally.
- ARESETn low while driving an ACK low -> SDA='z' in the same cycle; bank cleared; BUSY=0.

Source files
------------

// File: rtl/i2c_slave_if.sv
// i2c_slave local bank port: host-side read access plus
// write/read notification and bus-activity status.
interface i2c_slave_if #(
   parameter int PTR_W = 4
);
   logic [PTR_W-1:0] LOCAL_RADDR;
   logic [7:0]       LOCAL_RDATA;
   logic             WR_STROBE;
   logic [PTR_W-1:0] WR_ADDR;
   logic [7:0]       WR_DATA;
   logic             RD_STROBE;
   logic             BUSY;

   modport slave (
      input  LOCAL_RADDR,
      output LOCAL_RDATA,
      output WR_STROBE,
      output WR_ADDR,
      output WR_DATA,
      output RD_STROBE,
      output BUSY
   );

   modport master (
      output LOCAL_RADDR,
      input  LOCAL_RDATA,
      input  WR_STROBE,
      input  WR_ADDR,
      input  WR_DATA,
      input  RD_STROBE,
      input  BUSY
   );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with a byte register bank.
// First written byte sets the pointer; reads/writes auto-increment.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         NUM_REGS    = 16,
   parameter int         SYNC_STAGES = 2,
   localparam int        PTR_W       = $clog2(NUM_REGS)
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       SCL,
   inout  wire        SDA,
   i2c_slave_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_BYTE,
      S_WR_ACK,
      S_RD_BYTE,
      S_RD_ACK,
      S_WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;

   logic                   w_sda_pin;
   logic                   w_scl;
   logic                   w_sda;
   logic                   w_scl_rise;
   logic                   w_scl_fall;
   logic                   w_start;
   logic                   w_stop;

   state_t                 r_state;
   logic [3:0]             r_bitcnt;
   logic [7:0]             r_shift;
   logic [PTR_W-1:0]       r_ptr;
   logic                   r_first;
   logic                   r_rw;
   logic                   r_phase;
   logic                   r_oe;
   logic                   r_busy;
   logic                   r_wr_stb;
   logic [PTR_W-1:0]       r_wr_addr;
   logic [7:0]             r_wr_data;
   logic                   r_rd_stb;
   logic [7:0]             r_bank [NUM_REGS];

   state_t                 w_state_n;
   logic [3:0]             w_bitcnt_n;
   logic [7:0]             w_shift_n;
   logic [PTR_W-1:0]       w_ptr_n;
   logic                   w_first_n;
   logic                   w_rw_n;
   logic                   w_phase_n;
   logic                   w_oe_n;
   logic                   w_busy_n;
   logic                   w_wr_stb_n;
   logic [PTR_W-1:0]       w_wr_addr_n;
   logic [7:0]             w_wr_data_n;
   logic                   w_rd_stb_n;
   logic                   w_bank_we;
   logic                   w_load;
   logic                   w_sda_oe;

   logic [7:0]             w_byte;
   logic [7:0]             w_rd_byte;

   assign w_sda_pin  = SDA;
   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = ~w_sda & r_sda_d & w_scl;
   assign w_stop     = w_sda & ~r_sda_d & w_scl;

   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_rd_byte  = r_bank[r_ptr];

   // Bus conditions release SDA in the cycle they are seen.
   assign w_sda_oe   = r_oe & ~w_start & ~w_stop;
   assign SDA        = w_sda_oe ? 1'b0 : 1'bz;

   assign bus.LOCAL_RDATA = r_bank[bus.LOCAL_RADDR];
   assign bus.WR_STROBE   = r_wr_stb;
   assign bus.WR_ADDR     = r_wr_addr;
   assign bus.WR_DATA     = r_wr_data;
   assign bus.RD_STROBE   = r_rd_stb;
   assign bus.BUSY        = r_busy;

   // Synchronize SCL/SDA and keep one history flop for edges.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], w_sda_pin};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   // State and control registers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= S_IDLE;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_ptr     <= '0;
         r_first   <= 1'b0;
         r_rw      <= 1'b0;
         r_phase   <= 1'b0;
         r_oe      <= 1'b0;
         r_busy    <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_rd_stb  <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_bitcnt  <= w_bitcnt_n;
         r_shift   <= w_shift_n;
         r_ptr     <= w_ptr_n;
         r_first   <= w_first_n;
         r_rw      <= w_rw_n;
         r_phase   <= w_phase_n;
         r_oe      <= w_oe_n;
         r_busy    <= w_busy_n;
         r_wr_stb  <= w_wr_stb_n;
         r_wr_addr <= w_wr_addr_n;
         r_wr_data <= w_wr_data_n;
         r_rd_stb  <= w_rd_stb_n;
      end
   end

   // Register bank; written when a data byte completes.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= '0;
      end else if (w_bank_we) begin
         r_bank[r_ptr] <= w_byte;
      end
   end

   // Next-state and datapath decode; START/STOP win over bits.
   always_comb begin
      w_state_n   = r_state;
      w_bitcnt_n  = r_bitcnt;
      w_shift_n   = r_shift;
      w_ptr_n     = r_ptr;
      w_first_n   = r_first;
      w_rw_n      = r_rw;
      w_phase_n   = r_phase;
      w_oe_n      = r_oe;
      w_busy_n    = r_busy;
      w_wr_stb_n  = 1'b0;
      w_wr_addr_n = r_wr_addr;
      w_wr_data_n = r_wr_data;
      w_rd_stb_n  = 1'b0;
      w_bank_we   = 1'b0;
      w_load      = 1'b0;

      if (w_stop) begin
         w_state_n = S_IDLE;
         w_oe_n    = 1'b0;
         w_busy_n  = 1'b0;
      end else if (w_start) begin
         w_state_n  = S_ADDR;
         w_bitcnt_n = '0;
         w_oe_n     = 1'b0;
         w_busy_n   = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
            end
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_n  = w_byte;
                  w_bitcnt_n = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_rw_n = w_sda;
                     if (w_byte[7:1] == SLAVE_ADDR) begin
                        w_state_n = S_ADDR_ACK;
                        w_busy_n  = 1'b1;
                        w_phase_n = 1'b0;
                     end else begin
                        w_state_n = S_WAIT_STOP;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_WR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_phase) begin
                     w_oe_n    = 1'b1;
                     w_phase_n = 1'b1;
                  end else begin
                     w_oe_n     = 1'b0;
                     w_phase_n  = 1'b0;
                     w_bitcnt_n = '0;
                     if (r_state == S_WR_ACK) begin
                        w_state_n = S_WR_BYTE;
                     end else if (!r_rw) begin
                        w_state_n = S_WR_BYTE;
                        w_first_n = 1'b1;
                     end else begin
                        w_load = 1'b1;
                     end
                  end
               end
            end
            S_WR_BYTE: begin
               if (w_scl_rise) begin
                  w_shift_n  = w_byte;
                  w_bitcnt_n = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_state_n = S_WR_ACK;
                     w_phase_n = 1'b0;
                     if (r_first) begin
                        w_ptr_n   = w_byte[PTR_W-1:0];
                        w_first_n = 1'b0;
                     end else begin
                        w_bank_we   = 1'b1;
                        w_wr_stb_n  = 1'b1;
                        w_wr_addr_n = r_ptr;
                        w_wr_data_n = w_byte;
                        w_ptr_n     = r_ptr + PTR_W'(1);
                     end
                  end
               end
            end
            S_RD_BYTE: begin
               if (w_scl_fall) begin
                  if (r_bitcnt != 4'd8) begin
                     w_oe_n     = ~r_shift[7];
                     w_shift_n  = {r_shift[6:0], 1'b0};
                     w_bitcnt_n = r_bitcnt + 4'd1;
                  end else begin
                     w_oe_n    = 1'b0;
                     w_state_n = S_RD_ACK;
                     w_phase_n = 1'b0;
                  end
               end
            end
            S_RD_ACK: begin
               if (w_scl_rise) begin
                  if (w_sda) w_state_n = S_WAIT_STOP;
                  else       w_phase_n = 1'b1;
               end else if (w_scl_fall && r_phase) begin
                  w_load = 1'b1;
               end
            end
            S_WAIT_STOP: begin
            end
         endcase

         if (w_load) begin
            w_state_n  = S_RD_BYTE;
            w_phase_n  = 1'b0;
            w_oe_n     = ~w_rd_byte[7];
            w_shift_n  = {w_rd_byte[6:0], 1'b0};
            w_bitcnt_n = 4'd1;
            w_rd_stb_n = 1'b1;
            w_ptr_n    = r_ptr + PTR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a strobe scoreboard.
// Expected writes/reads are queued by stimulus, popped by a monitor.
module tb_i2c_slave;

   localparam int Q = 5;

   typedef struct {
      int a;
      int d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_lo = 1'b0;
   logic       sda_lo = 1'b0;
   logic       scl;
   wire        sda;

   int         tests = 0;
   int         fails = 0;
   wr_t        exp_wr[$];
   int         exp_rd[$];
   logic [7:0] mbank [16];
   logic [3:0] mptr;
   logic       busy_seen = 1'b0;
   logic       slave_low_seen = 1'b0;

   assign scl = ~scl_lo;
   assign sda = sda_lo ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave_if #(.PTR_W(4)) bus ();

   i2c_slave #(
      .SLAVE_ADDR (7'h50),
      .NUM_REGS   (16),
      .SYNC_STAGES(2)
   ) dut (
      .ACLK   (clk),
      .ARESETn(rst_n),
      .SCL    (scl),
      .SDA    (sda),
      .bus    (bus)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.BUSY) busy_seen = 1'b1;
            if (sda === 1'b0 && !sda_lo) slave_low_seen = 1'b1;
            if (bus.WR_STROBE || bus.RD_STROBE)
               chk("strobe_excl", int'(bus.WR_STROBE & bus.RD_STROBE), 0);
            if (bus.WR_STROBE) begin
               chk("wr_expected", int'(exp_wr.size() > 0), 1);
               if (exp_wr.size() > 0) begin
                  e = exp_wr.pop_front();
                  chk("wr_addr", int'(bus.WR_ADDR), e.a);
                  chk("wr_data", int'(bus.WR_DATA), e.d);
               end
            end
            if (bus.RD_STROBE) begin
               chk("rd_expected", int'(exp_rd.size() > 0), 1);
               if (exp_rd.size() > 0) void'(exp_rd.pop_front());
            end
         end
      end
   end

   task automatic wq();
      repeat (Q) @(posedge clk);
   endtask

   task automatic start_c();
      sda_lo = 1'b0; wq();
      scl_lo = 1'b0; wq();
      sda_lo = 1'b1; wq();
      scl_lo = 1'b1; wq();
   endtask

   task automatic stop_c();
      sda_lo = 1'b1; wq();
      scl_lo = 1'b0; wq();
      sda_lo = 1'b0; wq();
   endtask

   task automatic wbit(input logic b);
      sda_lo = ~b; wq();
      scl_lo = 1'b0; wq(); wq();
      scl_lo = 1'b1; wq();
   endtask

   task automatic rbit(output logic b);
      sda_lo = 1'b0; wq();
      scl_lo = 1'b0; wq();
      @(negedge clk);
      b = (sda === 1'b0) ? 1'b0 : 1'b1;
      wq();
      scl_lo = 1'b1; wq();
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(b);
      ack = ~b;
   endtask

   task automatic rbyte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(~ack);
   endtask

   task automatic send(input logic [7:0] d, input logic exp_ack,
                       input string name);
      logic a;
      wbyte(d, a);
      chk(name, int'(a), int'(exp_ack));
   endtask

   task automatic wdata(input logic [7:0] d);
      wr_t e;
      e.a = int'(mptr);
      e.d = int'(d);
      exp_wr.push_back(e);
      mbank[mptr] = d;
      mptr = mptr + 4'd1;
      send(d, 1'b1, "ack_data");
   endtask

   task automatic lread(input logic [3:0] idx, input logic [7:0] exp,
                        input string name);
      bus.LOCAL_RADDR = idx;
      @(negedge clk);
      chk(name, int'(bus.LOCAL_RDATA), int'(exp));
   endtask

   initial begin
      logic [7:0] d;
      bus.LOCAL_RADDR = '0;
      mptr = '0;
      for (int i = 0; i < 16; i++) mbank[i] = 8'h00;

      // Reset values
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(bus.BUSY), 0);
      chk("rst_wr_stb", int'(bus.WR_STROBE), 0);
      chk("rst_rd_stb", int'(bus.RD_STROBE), 0);
      chk("rst_wr_addr", int'(bus.WR_ADDR), 0);
      chk("rst_wr_data", int'(bus.WR_DATA), 0);
      chk("rst_sda_low", int'(sda === 1'b0), 0);
      chk("rst_rdata", int'(bus.LOCAL_RDATA), 0);
      rst_n = 1'b1;
      wq();

      // Pointer 3, two data bytes
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w");
      chk("busy_match", int'(bus.BUSY), 1);
      send(8'h03, 1'b1, "ack_ptr");
      mptr = 4'd3;
      wdata(8'hA5);
      wdata(8'h5A);
      stop_c();
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("busy_after_stop", int'(bus.BUSY), 0);
      lread(4'd4, 8'h5A, "bank4");
      lread(4'd3, 8'hA5, "bank3");

      // Pointer 2, repeated START, read three bytes
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w2");
      send(8'h02, 1'b1, "ack_ptr2");
      mptr = 4'd2;
      start_c();
      repeat (3) exp_rd.push_back(1);
      send(8'hA1, 1'b1, "ack_addr_r");
      for (int k = 0; k < 3; k++) begin
         rbyte(d, k < 2);
         chk("rd_data", int'(d), int'(mbank[mptr]));
         mptr = mptr + 4'd1;
      end
      @(negedge clk);
      chk("sda_rel_nack", int'(sda === 1'b0), 0);
      stop_c();

      // Wrong address: no ACK, no BUSY, no write
      busy_seen = 1'b0;
      slave_low_seen = 1'b0;
      start_c();
      send(8'hA2, 1'b0, "nack_addr");
      send(8'h03, 1'b0, "nack_ptr");
      send(8'h77, 1'b0, "nack_data");
      stop_c();
      chk("busy_wrong_addr", int'(busy_seen), 0);
      chk("sda_never_low", int'(slave_low_seen), 0);
      lread(4'd3, 8'hA5, "bank3_kept");

      // Pointer wrap at NUM_REGS
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w3");
      send(8'h0F, 1'b1, "ack_ptr_f");
      mptr = 4'hF;
      wdata(8'h11);
      wdata(8'h22);
      stop_c();
      lread(4'd15, 8'h11, "bank15_wrap");
      lread(4'd0, 8'h22, "bank0_wrap");

      // Pointer byte upper bits ignored
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w4");
      send(8'hF3, 1'b1, "ack_ptr_f3");
      mptr = 4'd3;
      wdata(8'h33);
      stop_c();
      lread(4'd3, 8'h33, "bank3_f3");

      // STOP after four data bits discards the byte
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w5");
      send(8'h05, 1'b1, "ack_ptr5");
      wbit(1'b1); wbit(1'b0); wbit(1'b0); wbit(1'b1);
      stop_c();
      lread(4'd5, 8'h00, "bank5_partial");
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w6");
      send(8'h05, 1'b1, "ack_ptr5b");
      mptr = 4'd5;
      wdata(8'h66);
      stop_c();
      lread(4'd5, 8'h66, "bank5_after");

      // Reset while the target drives an ACK
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w7");
      for (int i = 7; i >= 0; i--) wbit(i == 0);
      sda_lo = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("ack_driven", int'(sda === 1'b0), 1);
      bus.LOCAL_RADDR = 4'd3;
      rst_n = 1'b0;
      #1;
      chk("rst_sda_rel", int'(sda === 1'b0), 0);
      chk("rst_busy_mid", int'(bus.BUSY), 0);
      chk("rst_bank_clr", int'(bus.LOCAL_RDATA), 0);
      for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
      wq();
      rst_n = 1'b1;
      wq();

      // Normal transfer after reset
      start_c();
      send(8'hA0, 1'b1, "ack_addr_w8");
      send(8'h07, 1'b1, "ack_ptr7");
      mptr = 4'd7;
      wdata(8'hC3);
      stop_c();
      lread(4'd7, 8'hC3, "bank7_post_rst");
      lread(4'd5, 8'h00, "bank5_cleared");

      repeat (20) @(posedge clk);
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("rd_queue_empty", exp_rd.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
